// File: rtl/prog_clk_divider.sv
// prog_clk_divider: runtime-programmable divided clock and period tick.
// Produces clk_out with any integer period N >= 2 (high floor(N/2), low
// ceil(N/2)) and a one-cycle tick on the first cycle of every period.
// A new divisor is staged by div_load and takes effect only at a period
// boundary, so the output never glitches. Dropping en finishes the
// current period before going idle.
// Optional feature macro: CLK_DIV_SYNC_EN adds sync_in, which forces an
// early period boundary to realign phase to an external event.
module prog_clk_divider #(
    parameter int unsigned          CNT_W       = 32,
    parameter logic [CNT_W-1:0]     DIV_DEFAULT = CNT_W'(10000)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_active,
    output logic             div_err
);

    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Reject a default divisor that cannot form a period
    if (DIV_DEFAULT < DIV_MIN) begin : g_bad_default
        $error("prog_clk_divider: DIV_DEFAULT must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CNT_W-1:0] div_q, div_n;
    logic [CNT_W-1:0] pend_q, pend_q_n;
    logic             pend_v, pend_v_n;
    logic             clk_n, tick_n, err_n;
    logic             load_ok;
    logic             wrap_hit;
    logic             apply;
    logic             sync_hit;

`ifdef CLK_DIV_SYNC_EN
    assign sync_hit = sync_in;
`else
    assign sync_hit = 1'b0;
`endif

    assign div_active = div_q;

    // State, counter, divisor and registered outputs
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            div_q   <= DIV_DEFAULT;
            pend_q  <= '0;
            pend_v  <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            div_err <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            div_q   <= div_n;
            pend_q  <= pend_q_n;
            pend_v  <= pend_v_n;
            clk_out <= clk_n;
            tick    <= tick_n;
            div_err <= err_n;
        end
    end

    // Next state, divisor staging/application and next output values
    always_comb begin
        state_n  = state;
        count_n  = count;
        div_n    = div_q;
        pend_q_n = pend_q;
        pend_v_n = pend_v;
        clk_n    = 1'b0;
        tick_n   = 1'b0;
        apply    = 1'b0;

        load_ok  = div_load && (div_in >= DIV_MIN);
        err_n    = div_load && (div_in < DIV_MIN);
        // Sync acts as an early wrap; count < div_q always, so no overflow
        wrap_hit = (count == (div_q - ONE)) || sync_hit;

        if (load_ok) begin
            pend_q_n = div_in;
            pend_v_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                apply   = 1'b1;
                count_n = '0;
                if (en) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN, ST_STOP: begin
                if (wrap_hit) begin
                    apply   = 1'b1;
                    count_n = '0;
                    state_n = en ? ST_RUN : ST_IDLE;
                end else begin
                    count_n = count + ONE;
                    state_n = en ? ST_RUN : ST_STOP;
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = '0;
            end
        endcase

        // At a boundary a same-cycle valid load wins over the staged value
        if (apply) begin
            if (load_ok) begin
                div_n = div_in;
            end else if (pend_v) begin
                div_n = pend_q;
            end
            pend_v_n = 1'b0;
        end

        if (state_n != ST_IDLE) begin
            clk_n  = (count_n < (div_n >> 1));
            tick_n = (count_n == '0);
        end
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Testbench for prog_clk_divider: directed steps plus random traffic,
// checked every cycle against a period-level reference model.
module tb_prog_clk_divider;

    localparam int unsigned W   = 8;
    localparam int          DEF = 4;

    logic         clk_in;
    logic         rst;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         sync_drv;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] div_active;
    logic         div_err;

    int n_assert = 0;
    int n_fail   = 0;

    prog_clk_divider #(
        .CNT_W       (W),
        .DIV_DEFAULT (8'd4)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .div_load   (div_load),
`ifdef CLK_DIV_SYNC_EN
        .sync_in    (sync_drv),
`endif
        .clk_out    (clk_out),
        .tick       (tick),
        .div_active (div_active),
        .div_err    (div_err)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Reference model: a queue holding the remaining {tick,clk} pairs of
    // the period in progress; en and staged divisors matter only when the
    // queue runs dry (or a sync forces a new period).
    logic [1:0] m_q[$];
    int         m_div;
    int         m_pend;
    bit         m_pend_v;
    bit         m_run;
    int         m_len;
    logic       m_clk, m_tick, m_err;

    task automatic model_reset();
        m_q.delete();
        m_div    = DEF;
        m_pend   = 0;
        m_pend_v = 0;
        m_run    = 0;
        m_len    = 0;
        m_clk    = 0;
        m_tick   = 0;
        m_err    = 0;
    endtask

    function automatic int m_pos();
        return m_len - m_q.size() - 1;
    endfunction

    task automatic model_edge(bit e, bit ld, int din, bit sy);
        bit ok;
        bit boundary;
        ok       = ld && (din >= 2);
        m_err    = ld && (din < 2);
        boundary = !m_run || (m_q.size() == 0) || sy;
        if (boundary) begin
            if (ok) m_div = din;
            else if (m_pend_v) m_div = m_pend;
            m_pend_v = 0;
            m_q.delete();
            if (e) begin
                for (int i = 0; i < m_div; i++)
                    m_q.push_back({(i == 0), (i < m_div / 2)});
                m_len = m_div;
                m_run = 1;
            end else begin
                m_run = 0;
            end
        end else if (ok) begin
            m_pend   = din;
            m_pend_v = 1;
        end
        if (m_run) {m_tick, m_clk} = m_q.pop_front();
        else {m_tick, m_clk} = 2'b00;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the sampled inputs, then check
    task automatic step();
        @(posedge clk_in);
        model_edge(en, div_load, int'(div_in), sync_drv);
        #1;
        check("clk_out", 32'(clk_out), 32'(m_clk));
        check("tick", 32'(tick), 32'(m_tick));
        check("div_active", 32'(div_active), 32'(m_div));
        check("div_err", 32'(div_err), 32'(m_err));
    endtask

    task automatic load(int v);
        div_load = 1'b1;
        div_in   = W'(v);
        step();
        div_load = 1'b0;
    endtask

    task automatic wait_pos(int p);
        int k;
        k = 0;
        while (!(m_run && m_pos() == p) && k < 600) begin
            step();
            k++;
        end
        check("wait_pos_timeout", 32'(k < 600), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_run && k < 600) begin
            step();
            k++;
        end
        check("wait_idle_timeout", 32'(k < 600), 32'd1);
    endtask

    initial begin
        int last;
        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = '0;
        sync_drv = 1'b0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_div_active", 32'(div_active), 32'd4);
        check("rst_div_err", 32'(div_err), 32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        en  = 1'b1;

        // Default period 4 from the first edge
        step();
        check("first_tick", 32'(tick), 32'd1);
        check("first_clk", 32'(clk_out), 32'd1);
        repeat (12) step();

        // Odd period 5, tick spacing measured on the DUT
        en = 1'b0;
        wait_idle();
        load(5);
        check("load5_active", 32'(div_active), 32'd5);
        en   = 1'b1;
        last = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (tick === 1'b1) begin
                if (last >= 0) check("tick_spacing5", 32'(i - last), 32'd5);
                last = i;
            end
        end

        // Mid-period reload: current period of 6 completes first
        en = 1'b0;
        wait_idle();
        load(6);
        en = 1'b1;
        wait_pos(2);
        load(3);
        check("midload_active_kept", 32'(div_active), 32'd6);
        repeat (14) step();
        load(6);
        repeat (8) step();
        wait_pos(5);
        load(3);
        check("wrap_bypass_active", 32'(div_active), 32'd3);
        check("wrap_bypass_tick", 32'(tick), 32'd1);
        repeat (7) step();

        // Rejected loads
        load(1);
        check("err_div1", 32'(div_err), 32'd1);
        check("err_div1_active", 32'(div_active), 32'd3);
        step();
        check("err_clear", 32'(div_err), 32'd0);
        load(0);
        check("err_div0", 32'(div_err), 32'd1);
        check("err_div0_active", 32'(div_active), 32'd3);
        repeat (4) step();

        // Stop at count 1 of period 8 finishes the period, then restart
        en = 1'b0;
        wait_idle();
        load(8);
        en = 1'b1;
        wait_pos(1);
        en = 1'b0;
        repeat (7) step();
        check("stop_idle_clk", 32'(clk_out), 32'd0);
        check("stop_idle_tick", 32'(tick), 32'd0);
        repeat (3) step();
        check("stop_hold_clk", 32'(clk_out), 32'd0);
        en = 1'b1;
        step();
        check("restart_tick", 32'(tick), 32'd1);
        check("restart_clk", 32'(clk_out), 32'd1);

        // Boundary divisors: minimum 2 and maximum 2^W-1
        load(2);
        repeat (10) step();
        load(255);
        repeat (520) step();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            div_load = ($urandom_range(0, 7) == 0);
            div_in   = W'($urandom_range(0, 12));
`ifdef CLK_DIV_SYNC_EN
            sync_drv = ($urandom_range(0, 49) == 0);
`endif
            step();
        end
        div_load = 1'b0;
        sync_drv = 1'b0;

        // Asynchronous reset mid-high phase discards a pending divisor
        en = 1'b0;
        wait_idle();
        load(8);
        en = 1'b1;
        wait_pos(0);
        load(7);
        check("pre_rst_clk_high", 32'(clk_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_clk", 32'(clk_out), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        check("async_rst_active", 32'(div_active), 32'd4);
        model_reset();
        @(negedge clk_in);
        rst = 1'b0;
        repeat (10) step();
        check("post_rst_active", 32'(div_active), 32'd4);

`ifdef CLK_DIV_SYNC_EN
        // Sync pulse at count 3 of 8 restarts the period
        load(8);
        wait_pos(3);
        sync_drv = 1'b1;
        step();
        sync_drv = 1'b0;
        check("sync_tick", 32'(tick), 32'd1);
        check("sync_clk", 32'(clk_out), 32'd1);
        repeat (10) step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
Runtime-programmable clock-enable/divided-clock generator, the parametrised successor to the fixed-ratio divider. It produces a registered divided clock of any integer period N ≥ 2 (not only even periods) and a one-cycle tick at each period start. The divisor is reloadable at run time with glitch-free update at the period boundary. It also supports clean start/stop. It feeds slow-domain logic (display scan, debouncers, SPM step clock) from the board clock.

Parameters:
CNT_W, 32, width of counter, divisor and readback.
DIV_DEFAULT, 10000, period in clk_in cycles loaded at reset; must be ≥ 2 (elaboration error otherwise).

Ports:
clk_in  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  run request; level-sensitive.
div_in  input  CNT_W  new period value in clk_in cycles.
div_load  input  1  one-cycle strobe capturing div_in.
clk_out  output  1  registered divided clock.
tick  output  1  registered one-cycle pulse on the first cycle of each period.
div_active  output  CNT_W  period currently in force.
div_err  output  1  one-cycle pulse: rejected load (div_in < 2).

Behaviour:
- Reset (async, rst=1):
  - count=0, div_q=DIV_DEFAULT, pend_v=0, state=IDLE.
  - clk_out=0, tick=0, div_err=0, div_active=DIV_DEFAULT.
- States: IDLE, RUN, STOP.
- IDLE:
  - count=0, clk_out=0, tick=0.
  - en=1 → next edge: RUN, count=0, clk_out=1, tick=1. The pending divisor, if any, is applied on that edge.
- RUN:
  - count increments.
  - At count==div_q-1 the next count is 0 (wrap) and tick=1 for that cycle.
  - en=0 → STOP.
- STOP:
  - Continues counting identically to RUN until the wrap edge, then goes to IDLE (count=0, clk_out=0, tick=0).
  - en=1 while in STOP → back to RUN; no period disturbance.
  - The last period is never truncated.
- Output relation, in RUN/STOP every cycle:
  - clk_out == (count < div_q>>1).
  - tick == (count==0).
  - Period is exactly div_q cycles; high for floor(div_q/2), low for ceil(div_q/2).
  - Example: div_q=3 gives high 1, low 2.
- Divisor load:
  - div_load=1 with div_in ≥ 2 → pend_q=div_in, pend_v=1.
  - A later load before application overwrites it (latest wins).
  - div_load=1 with div_in < 2 → ignored, div_err=1 next cycle, pending state unchanged.
- Application:
  - pend_v=1 is applied (div_q←pend_q, pend_v←0) on the wrap edge or any edge in IDLE.
  - A div_load coinciding with the wrap edge bypasses: that div_in takes effect at this wrap.
- div_active = div_q (registered, updated on application edge).
- Counter compare uses full CNT_W; div_q=2^CNT_W-1 is legal. No overflow because count < div_q always.
- rst mid-period: immediate return to reset values; the pending load is discarded.

Optional Feature:
CLK_DIV_SYNC_EN:
- Defined: adds input port sync_in (1 bit).
  - sync_in=1 in RUN/STOP → next edge count=0, clk_out=1, tick=1, pending divisor applied. This realigns phase to an external event.
  - sync_in in IDLE → no effect.
  - sync_in in STOP → counts as a wrap, so the block enters IDLE.
- Undefined: no sync_in port; phase is determined only by en and wrap.

Test Plan:
1. Reset with DIV_DEFAULT=4, en=1 at cycle 0 → clk_out 1100 repeating, tick every 4th cycle starting cycle 1, div_active=4.
2. Odd period: load div_in=5 while IDLE, en=1 → clk_out high 2 / low 3, period 5; tick spacing 5.
3. Mid-period reload: running at 6, pulse div_load with div_in=3 at count=2 → current period completes 6 cycles, next periods are 3. Repeat the load exactly at count=5 → new period applied at that wrap.
4. Invalid load: div_in=1 → div_err pulses one cycle, div_active unchanged. Then div_in=0 → same.
5. Stop/restart: en drops at count=1 of a period of 8 → 7 further cycles, then clk_out=0, count held. en=1 → tick on the next edge.
6. rst asserted asynchronously mid-high phase → clk_out=0 and tick=0 immediately; pending div_in=7 is discarded, div_active=DIV_DEFAULT. With CLK_DIV_SYNC_EN, a sync_in pulse at count=3 of 8 → next cycle count=0, tick=1.
